// File: rtl/mult_share_ctrl_pkg.sv
// Shared definitions for the two-requester multiplier controller:
// state encoding, settle-counter width and the round-robin grant rule.
package mult_share_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    // Returns the winning requester index; on a tie the one that did not win last time.
    function automatic logic rr_grant(input logic v0, input logic v1, input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/mult_share_ctrl_multiplier.sv
// Unsigned array multiplier: one AND-gated partial-product row per bit of b,
// accumulated by a chain of row adders. Purely combinational.
module multiplier #(
    parameter int A_WIDTH = 4,
    parameter int B_WIDTH = 4
) (
    input  logic [A_WIDTH-1:0]         a,
    input  logic [B_WIDTH-1:0]         b,
    output logic [A_WIDTH+B_WIDTH-1:0] p
);

    localparam int PW = A_WIDTH + B_WIDTH;

    logic [PW-1:0] row_sum_s [B_WIDTH+1];

    assign row_sum_s[0] = {PW{1'b0}};

    for (genvar i = 0; i < B_WIDTH; i++) begin : g_row
        logic [PW-1:0] pp_s;
        assign pp_s             = {{B_WIDTH{1'b0}}, a & {A_WIDTH{b[i]}}} << i;
        assign row_sum_s[i + 1] = row_sum_s[i] + pp_s;
    end

    assign p = row_sum_s[B_WIDTH];

endmodule

// File: rtl/mult_share_ctrl.sv
// Arbitrates two requesters onto one array multiplier; the product is given
// SETTLE_CYCLES cycles to settle (multicycle path) before being captured.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int OPER_LENGTH   = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Req0Valid,
    output logic                       Req0Ready,
    input  logic [OPER_LENGTH-1:0]     Req0X,
    input  logic [OPER_LENGTH-1:0]     Req0Y,
    input  logic                       Req1Valid,
    output logic                       Req1Ready,
    input  logic [OPER_LENGTH-1:0]     Req1X,
    input  logic [OPER_LENGTH-1:0]     Req1Y,
    output logic                       RespValid,
    input  logic                       RespReady,
    output logic                       RespId,
    output logic [2*OPER_LENGTH-1:0]   RespResult
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e                      state_q, state_d;
    logic [OPER_LENGTH-1:0]      opx_q, opx_d;
    logic [OPER_LENGTH-1:0]      opy_q, opy_d;
    logic [2*OPER_LENGTH-1:0]    result_q, result_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        id_q, id_d;
    logic                        last_q, last_d;
    logic [2*OPER_LENGTH-1:0]    prod_s;
    logic                        grant_s;
    logic                        rdy0_s;
    logic                        rdy1_s;

    // Operands are only written on acceptance, so the multiplier inputs stay frozen through COMPUTE.
    multiplier #(
        .A_WIDTH(OPER_LENGTH),
        .B_WIDTH(OPER_LENGTH)
    ) u_multiplier (
        .a(opx_q),
        .b(opy_q),
        .p(prod_s)
    );

    // Next-state, grant and operand/result capture logic.
    always_comb begin
        state_d  = state_q;
        opx_d    = opx_q;
        opy_d    = opy_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        id_d     = id_q;
        last_d   = last_q;
        rdy0_s   = 1'b0;
        rdy1_s   = 1'b0;
        grant_s  = rr_grant(Req0Valid, Req1Valid, last_q);

        case (state_q)
            ST_IDLE: begin
                rdy0_s = Req0Valid & ~grant_s;
                rdy1_s = Req1Valid & grant_s;
                if (rdy0_s || rdy1_s) begin
                    if (grant_s) begin
                        opx_d = Req1X;
                        opy_d = Req1Y;
                    end else begin
                        opx_d = Req0X;
                        opy_d = Req0Y;
                    end
                    id_d    = grant_s;
                    last_d  = grant_s;
                    cnt_d   = SETTLE_LOAD;
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    result_d = prod_s;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                if (RespReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            opx_q    <= {OPER_LENGTH{1'b0}};
            opy_q    <= {OPER_LENGTH{1'b0}};
            result_q <= {(2*OPER_LENGTH){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            id_q     <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            opx_q    <= opx_d;
            opy_q    <= opy_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            last_q   <= last_d;
        end
    end

    assign Req0Ready  = rdy0_s;
    assign Req1Ready  = rdy1_s;
    assign RespValid  = (state_q == ST_DONE);
    assign RespId     = id_q;
    assign RespResult = result_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_mult_share_ctrl;

    localparam int W  = 3;
    localparam int S  = 2;
    localparam int PW = 2 * W;
    localparam int WB = 4;
    localparam int SB = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic          v0 = 1'b0, v1 = 1'b0, resp_ready = 1'b0;
    logic [W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic          r0, r1, rv, rid;
    logic [PW-1:0] rres;

    // instance B: 4-bit operands, single settle cycle
    logic            bv0 = 1'b0, bresp_ready = 1'b0;
    logic            bv1 = 1'b0;
    logic [WB-1:0]   bx0 = '0, by0 = '0, bx1 = '0, by1 = '0;
    logic            br0, br1, brv, brid;
    logic [2*WB-1:0] bres;

    int errors = 0;
    int checks = 0;

    mult_share_ctrl #(.OPER_LENGTH(W), .SETTLE_CYCLES(S)) dut (
        .CLK(clk), .RST(rst),
        .Req0Valid(v0), .Req0Ready(r0), .Req0X(x0), .Req0Y(y0),
        .Req1Valid(v1), .Req1Ready(r1), .Req1X(x1), .Req1Y(y1),
        .RespValid(rv), .RespReady(resp_ready), .RespId(rid), .RespResult(rres)
    );

    mult_share_ctrl #(.OPER_LENGTH(WB), .SETTLE_CYCLES(SB)) dut_b (
        .CLK(clk), .RST(rst),
        .Req0Valid(bv0), .Req0Ready(br0), .Req0X(bx0), .Req0Y(by0),
        .Req1Valid(bv1), .Req1Ready(br1), .Req1X(bx1), .Req1Y(by1),
        .RespValid(brv), .RespReady(bresp_ready), .RespId(brid), .RespResult(bres)
    );

    // Reference model: one job at most; m_age counts edges since acceptance.
    bit            m_busy = 1'b0;
    int            m_age  = 0;
    bit            m_id   = 1'b0;
    bit            m_last = 1'b1;
    logic [PW-1:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_id   <= 1'b0;
            m_last <= 1'b1;
            m_prod <= '0;
        end else if (!m_busy) begin
            if (v0 && (!v1 || m_last)) begin
                m_busy <= 1'b1; m_age <= 1; m_id <= 1'b0; m_last <= 1'b0;
                m_prod <= PW'(int'(x0) * int'(y0));
            end else if (v1) begin
                m_busy <= 1'b1; m_age <= 1; m_id <= 1'b1; m_last <= 1'b1;
                m_prod <= PW'(int'(x1) * int'(y1));
            end
        end else if (m_age > S && resp_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit ev, e0, e1;
        if (!rst) begin
            ev = m_busy && (m_age > S);
            e0 = !m_busy && v0 && (!v1 || m_last);
            e1 = !m_busy && v1 && (!v0 || !m_last);
            chk("model_Req0Ready", {63'd0, r0}, {63'd0, e0});
            chk("model_Req1Ready", {63'd0, r1}, {63'd0, e1});
            chk("model_RespValid", {63'd0, rv}, {63'd0, ev});
            if (ev) begin
                chk("model_RespId", {63'd0, rid}, {63'd0, m_id});
                chk("model_RespResult", {58'd0, rres}, {58'd0, m_prod});
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, rv}, 64'd0);
        chk("rst_result", {58'd0, rres}, 64'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [WB-1:0] rx, ry;
        rst = 1'b1;
        #2;
        chk("por_RespValid", {63'd0, rv}, 64'd0);
        chk("por_RespId", {63'd0, rid}, 64'd0);
        chk("por_RespResult", {58'd0, rres}, 64'd0);
        chk("por_b_RespResult", {56'd0, bres}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // single requester 5x7
        v0 = 1'b1; x0 = 3'd5; y0 = 3'd7; #1;
        chk("s1_ready0", {63'd0, r0}, 64'd1);
        tick();
        v0 = 1'b0; x0 = 3'd0; y0 = 3'd0;
        chk("s1_valid_e0", {63'd0, rv}, 64'd0);
        tick();
        chk("s1_valid_e1", {63'd0, rv}, 64'd0);
        tick();
        chk("s1_valid_e2", {63'd0, rv}, 64'd1);
        chk("s1_result", {58'd0, rres}, 64'd35);
        chk("s1_id", {63'd0, rid}, 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("s1_released", {63'd0, rv}, 64'd0);
        resp_ready = 1'b0;

        // tie after reset: requester 0 first, then requester 1
        pulse_reset();
        v0 = 1'b1; x0 = 3'd7; y0 = 3'd7;
        v1 = 1'b1; x1 = 3'd3; y1 = 3'd2;
        resp_ready = 1'b1; #1;
        chk("s2_ready0", {63'd0, r0}, 64'd1);
        chk("s2_ready1", {63'd0, r1}, 64'd0);
        tick();
        v0 = 1'b0; #1;
        chk("s2_noready_e0", {63'd0, r1}, 64'd0);
        tick();
        chk("s2_noready_e1", {63'd0, r1}, 64'd0);
        tick();
        chk("s2_noready_e2", {63'd0, r1}, 64'd0);
        chk("s2_result0", {58'd0, rres}, 64'd49);
        chk("s2_id0", {63'd0, rid}, 64'd0);
        tick();
        chk("s2_ready1_after", {63'd0, r1}, 64'd1);
        tick();
        v1 = 1'b0;
        tick();
        tick();
        chk("s2_valid1", {63'd0, rv}, 64'd1);
        chk("s2_result1", {58'd0, rres}, 64'd6);
        chk("s2_id1", {63'd0, rid}, 64'd1);
        tick();
        resp_ready = 1'b0;

        // back-pressure: hold 6x6 for five cycles
        v0 = 1'b1; x0 = 3'd6; y0 = 3'd6;
        tick();
        v1 = 1'b1; x0 = 3'd1; x1 = 3'd2; y1 = 3'd3;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("s3_valid", {63'd0, rv}, 64'd1);
            chk("s3_result", {58'd0, rres}, 64'd36);
            chk("s3_id", {63'd0, rid}, 64'd0);
            chk("s3_ready0", {63'd0, r0}, 64'd0);
            chk("s3_ready1", {63'd0, r1}, 64'd0);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // operand change after acceptance
        v0 = 1'b1; x0 = 3'd4; y0 = 3'd3;
        tick();
        v0 = 1'b0; x0 = 3'd0;
        tick();
        tick();
        chk("s4_valid", {63'd0, rv}, 64'd1);
        chk("s4_result", {58'd0, rres}, 64'd12);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // reset during COMPUTE
        v0 = 1'b1; x0 = 3'd7; y0 = 3'd5;
        tick();
        v0 = 1'b0;
        tick();
        pulse_reset();
        chk("s5_id_after_rst", {63'd0, rid}, 64'd0);
        resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("s5_no_resp", {63'd0, rv}, 64'd0);
        end
        resp_ready = 1'b0;
        v0 = 1'b1; x0 = 3'd2; y0 = 3'd3;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        chk("s5_next_valid", {63'd0, rv}, 64'd1);
        chk("s5_next_result", {58'd0, rres}, 64'd6);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // instance B: 15x15 one edge after acceptance
        bv0 = 1'b1; bx0 = 4'd15; by0 = 4'd15; #1;
        chk("b_ready0", {63'd0, br0}, 64'd1);
        chk("b_ready1", {63'd0, br1}, 64'd0);
        tick();
        bv0 = 1'b0;
        chk("b_valid_e0", {63'd0, brv}, 64'd0);
        tick();
        chk("b_valid_e1", {63'd0, brv}, 64'd1);
        chk("b_result", {56'd0, bres}, 64'd225);
        chk("b_id", {63'd0, brid}, 64'd0);
        bresp_ready = 1'b1;
        tick();
        chk("b_released", {63'd0, brv}, 64'd0);
        bresp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rx = WB'($urandom_range(15));
            ry = WB'($urandom_range(15));
            bv0 = 1'b1; bx0 = rx; by0 = ry;
            tick();
            bv0 = 1'b0; bx0 = '0;
            tick();
            chk("b_rand_valid", {63'd0, brv}, 64'd1);
            chk("b_rand_result", {56'd0, bres}, 64'(int'(rx) * int'(ry)));
            bresp_ready = 1'b1;
            tick();
            bresp_ready = 1'b0;
        end

        // random traffic on instance A
        for (int c = 0; c < 3000; c++) begin
            v0 = ($urandom_range(3) != 0);
            v1 = ($urandom_range(2) != 0);
            x0 = W'($urandom_range(7));
            y0 = W'($urandom_range(7));
            x1 = W'($urandom_range(7));
            y1 = W'($urandom_range(7));
            resp_ready = ($urandom_range(1) != 0);
            rst = ($urandom_range(249) == 0);
            tick();
        end
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; resp_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
MULT_SHARE_CTRL -- requirements
Module: mult_share_ctrl

Interface
REQ-001 SHALL have parameter OPER_LENGTH, default 3, operand width in bits for both operands.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, number of cycles allowed for the combinational array product to settle; legal range 1..15.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Req0Valid  input  1  requester 0 has an operand pair.
REQ-006 SHALL have port Req0Ready  output  1  requester 0 pair accepted this cycle when Req0Valid is also high.
REQ-007 SHALL have port Req0X / Req0Y  input  OPER_LENGTH each  requester 0 operands.
REQ-008 SHALL have port Req1Valid / Req1Ready / Req1X / Req1Y, identical to REQ-005..007, for requester 1.
REQ-009 SHALL have port RespValid  output  1  result available.
REQ-010 SHALL have port RespReady  input  1  consumer accepts result.
REQ-011 SHALL have port RespId  output  1  requester index that owns the result.
REQ-012 SHALL have port RespResult  output  2*OPER_LENGTH  unsigned product.

Function
REQ-013 SHALL share one unsigned array multiplier instance between two requesters, one operation in flight at a time.
REQ-014 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-015 SHALL, in IDLE, drive ReqNReady high combinationally only for the granted requester; both Ready signals SHALL be low in COMPUTE and DONE.
REQ-016 SHALL grant as follows: if exactly one ReqNValid is high, grant that requester; if both are high, grant the requester not equal to LastGrant (round-robin).
REQ-017 SHALL, on a handshake (Valid and Ready high at an edge), register X and Y into operand registers feeding the multiplier, set Id and LastGrant to the granted index, load the settle counter with SETTLE_CYCLES-1, and enter COMPUTE.
REQ-018 SHALL, in COMPUTE, decrement the counter each cycle; when the counter is 0, register the multiplier output into the result register and enter DONE.
REQ-019 SHALL assert RespValid on the SETTLE_CYCLES-th rising edge after the accepting edge.
REQ-020 SHALL hold RespValid, RespId and RespResult stable while RespValid is high and RespReady is low.
REQ-021 SHALL, in DONE with RespReady high, deassert RespValid on that edge and return to IDLE; no new request is accepted in that same cycle.
REQ-022 SHALL have a best-case throughput of one operation per SETTLE_CYCLES+2 cycles.
REQ-023 SHALL ignore operand changes on ReqNX/ReqNY after acceptance; the result depends only on the captured values.
REQ-024 SHALL hold the multiplier inputs constant throughout COMPUTE (multicycle path).

Reset
REQ-025 SHALL, on RST, immediately enter IDLE, clear the operand, result and counter registers to 0, and drive RespValid 0, RespId 0 and RespResult 0.
REQ-026 SHALL set LastGrant to 1 on reset, so requester 0 wins the first tie.
REQ-027 SHALL, on RST asserted mid-COMPUTE or mid-DONE, discard the in-flight operation; no response is produced for it after reset release.

Structure
REQ-028 SHALL place the FSM state encoding (2-bit: IDLE=0, COMPUTE=1, DONE=2) and the counter width constant (4 bits) in a shared package.
REQ-029 SHALL instantiate the existing structural array multiplier as its single sub-module (name: multiplier), with both operand widths set to OPER_LENGTH.

Verification
REQ-030 SHALL cover: only Req0 valid, X=5, Y=7 -> Req0Ready high in IDLE; RespValid 2 edges after acceptance; RespResult=35, RespId=0.
REQ-031 SHALL cover: both requests valid after reset, Req0 7x7 and Req1 3x2 -> Req0 served first (49, Id 0), then Req1 (6, Id 1), with no Ready in between.
REQ-032 SHALL cover: RespReady held low 5 cycles with result 6x6=36 -> RespValid/RespResult/RespId stable all 5 cycles; both Ready signals low.
REQ-033 SHALL cover: Req0 X changed to 0 during COMPUTE after accepting 4x3 -> result 12.
REQ-034 SHALL cover: RST pulsed one cycle after accepting 7x5 -> all outputs 0 immediately; no response after release; next request is served normally.
REQ-035 SHALL cover: SETTLE_CYCLES=1 and OPER_LENGTH=4, 15x15 -> 225 one edge after acceptance.
